movavg_inv: RTL

Inverse filter for the two-lane moving-sum datapath. It sits at the consuming end of the movavg link and takes one pair of moving sums per beat (lane A, lane B). From each pair it reconstructs the original pair of input samples exactly, modulo 2^W, using a recursive difference against its own reconstructed history. A valid/ready handshake and a registered output stage allow backpressure without loss. A synchronous clear realigns the history with the forward filter's reset.

---
 rtl/movavg_inv_if.sv | 9 +
 rtl/movavg_inv.sv | 50 +++++
 2 files changed

// File: rtl/movavg_inv_if.sv
// movavg_inv_if: valid/ready stream carrying one lane-A/lane-B word pair per beat.
interface movavg_inv_if #(parameter int W = 64);
  logic         valid;
  logic         ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  modport master (output valid, a, b, input ready);
  modport slave  (input valid, a, b, output ready);
endinterface

// File: rtl/movavg_inv.sv
// movavg_inv: inverse of the two-lane moving-sum filter; rebuilds the original sample pair from each sum pair.
module movavg_inv #(
  parameter int W  = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  movavg_inv_if.slave   in_if,
  movavg_inv_if.master  out_if,
  output logic [CW-1:0] beat_count
);
  logic [W-1:0] pa1, pb1, pa2;
  logic [W-1:0] ha1, hb1, ha2;
  logic [W-1:0] a_k, b_k;
  logic         acc;
  assign in_if.ready = !out_if.valid || out_if.ready;
  assign acc = in_if.valid && in_if.ready;
  // clear makes a same-cycle beat see zero history, as after a forward-filter reset
  assign ha1 = clear ? '0 : pa1;
  assign hb1 = clear ? '0 : pb1;
  assign ha2 = clear ? '0 : pa2;
  assign b_k = in_if.b - ha1 - hb1 - ha2;
  assign a_k = in_if.a - b_k - ha1 - hb1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa1          <= '0;
      pb1          <= '0;
      pa2          <= '0;
      beat_count   <= '0;
      out_if.valid <= 1'b0;
      out_if.a     <= '0;
      out_if.b     <= '0;
    end else begin
      if (acc || clear) begin
        pa2 <= acc ? ha1 : '0;
        pa1 <= acc ? a_k : '0;
        pb1 <= acc ? b_k : '0;
      end
      beat_count <= (clear ? '0 : beat_count) + {{(CW-1){1'b0}}, acc};
      if (acc) begin
        out_if.valid <= 1'b1;
        out_if.a     <= a_k;
        out_if.b     <= b_k;
      end else if (out_if.ready) begin
        out_if.valid <= 1'b0;
      end
    end
  end
endmodule
